// File: rtl/spdif_pkg.sv
// Shared constants and helpers for the IEC 60958 (S/PDIF) transmitter.
// Preamble patterns are listed first-cell-first (MSB goes out first).
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [3:0] FS_48K  = 4'b0010;
    localparam logic [3:0] FS_44K1 = 4'b0000;

    localparam int CELLS_PER_FRAME  = 128;
    localparam int FRAMES_PER_BLOCK = 192;

    // Consumer channel status: bit 2 (no copy protection) and the rate field
    function automatic logic cs_bit(input logic [7:0] n, input logic [3:0] fs);
        logic b;
        b = 1'b0;
        if (n == 8'd2) begin
            b = 1'b1;
        end else if (n >= 8'd24 && n <= 8'd27) begin
            b = fs[n[1:0]];
        end
        return b;
    endfunction

endpackage

// File: rtl/spdif_if.sv
// Sample-pair handshake between the audio source and the transmitter.
// The pair is taken only on the frame-start tick; ack marks that cycle.
interface spdif_if;

    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        sample_valid;
    logic        sample_ack;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ack
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ack
    );

endinterface

// File: rtl/spdif_subframe.sv
// Combinational subframe word: payload[i] is the bit sent in slot 4+i.
// Layout: sample[23:0], V, U, C, P with P giving even parity.
module spdif_subframe (
    input  logic [23:0] sample_i,
    input  logic        v_i,
    input  logic        c_i,
    output logic [27:0] payload_o
);

    logic u;
    logic p;

    assign u         = 1'b0;
    assign p         = ^{c_i, u, v_i, sample_i};
    assign payload_o = {p, c_i, u, v_i, sample_i};

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter: divider, cell/frame sequencing and biphase-mark line.
// Each tick starts the cell held in cell_q, then advances it.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int unsigned DIV     = 4,
    parameter logic [3:0]  FS_CODE = FS_48K
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable,
    spdif_if.slave smp,
    output logic   spdif_o
);

    logic [7:0]  div_q;
    logic [6:0]  cell_q;
    logic [7:0]  frame_q;
    logic [23:0] left_q;
    logic [23:0] right_q;
    logic        v_q;
    logic        pinv_q;
    logic        spdif_q;

    logic        tick;
    logic        start;
    logic        pre;
    logic [4:0]  slot;
    logic [4:0]  idx;
    logic [7:0]  pat;
    logic        c_bit;
    logic [23:0] sample;
    logic [27:0] payload;
    logic        spdif_d;
    logic        pinv_d;

    assign tick  = enable && (div_q == 8'(DIV - 1));
    assign start = tick && (cell_q == 7'd0);
    assign slot  = cell_q[5:1];
    assign idx   = slot - 5'd4;
    assign pre   = (slot < 5'd4);
    assign c_bit = cs_bit(frame_q, FS_CODE);

    assign sample = cell_q[6] ? right_q : left_q;
    assign pat    = cell_q[6] ? PRE_W
                  : (frame_q == 8'd0) ? PRE_B : PRE_M;

    assign smp.sample_ack = start && smp.sample_valid;
    assign spdif_o        = spdif_q;

    spdif_subframe u_subframe (
        .sample_i  (sample),
        .v_i       (v_q),
        .c_i       (c_bit),
        .payload_o (payload)
    );

    // Preamble polarity is fixed by the line level before its first cell
    always_comb begin
        pinv_d  = pinv_q;
        spdif_d = spdif_q;
        if (pre) begin
            if (cell_q[2:0] == 3'd0) begin
                pinv_d  = spdif_q;
                spdif_d = pat[7] ^ spdif_q;
            end else begin
                spdif_d = pat[3'd7 - cell_q[2:0]] ^ pinv_q;
            end
        end else if (!cell_q[0]) begin
            spdif_d = ~spdif_q;
        end else begin
            spdif_d = spdif_q ^ payload[idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            cell_q  <= '0;
            frame_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            v_q     <= 1'b0;
            pinv_q  <= 1'b0;
            spdif_q <= 1'b0;
        end else if (!enable) begin
            div_q   <= '0;
            cell_q  <= '0;
            frame_q <= '0;
            pinv_q  <= 1'b0;
            spdif_q <= 1'b0;
        end else begin
            div_q <= tick ? 8'd0 : div_q + 8'd1;
            if (tick) begin
                cell_q  <= cell_q + 7'd1;
                spdif_q <= spdif_d;
                pinv_q  <= pinv_d;
                if (cell_q == 7'(CELLS_PER_FRAME - 1)) begin
                    frame_q <= (frame_q == 8'(FRAMES_PER_BLOCK - 1))
                             ? 8'd0 : frame_q + 8'd1;
                end
                if (start) begin
                    left_q  <= smp.sample_valid ? smp.left_data : '0;
                    right_q <= smp.sample_valid ? smp.right_data : '0;
                    v_q     <= ~smp.sample_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench: decodes the biphase line cell by cell and checks frames.
// dut0 (DIV=4) runs the short scenarios, dut1 (DIV=2) the 193-frame run.
module tb_spdif_tx;
    import spdif_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic en0;
    logic en1;
    logic line0;
    logic line1;

    spdif_if bus0 ();
    spdif_if bus1 ();

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ack0_n    = 0;
    int ack1_n    = 0;
    int ack0_last = 0;
    int ack0_prev = 0;
    int line_err  = 0;
    int run       = 0;
    logic prevc   = 1'b0;

    spdif_tx #(.DIV(4), .FS_CODE(4'b0010)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (en0),
        .smp     (bus0),
        .spdif_o (line0)
    );

    spdif_tx #(.DIV(2), .FS_CODE(4'b0010)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (en1),
        .smp     (bus1),
        .spdif_o (line1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus0.sample_ack) begin
            ack0_n++;
            ack0_prev = ack0_last;
            ack0_last = cyc;
        end
        if (bus1.sample_ack) ack1_n++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic get_cell(input int s, output logic c);
        repeat ((s != 0) ? 2 : 4) @(posedge clk);
        @(negedge clk);
        c = (s != 0) ? line1 : line0;
    endtask

    task automatic rx_sub(input int s, output logic [7:0] pre,
                          output logic [27:0] d);
        logic a, b, inv;
        inv = prevc;
        for (int i = 0; i < 8; i++) begin
            get_cell(s, a);
            pre[7 - i] = a ^ inv;
            prevc = a;
        end
        run = 0;
        for (int k = 0; k < 28; k++) begin
            get_cell(s, a);
            if (a == prevc) line_err++;
            run = (a == prevc) ? run + 1 : 1;
            if (run > 3) line_err++;
            get_cell(s, b);
            run = (b == a) ? run + 1 : 1;
            if (run > 3) line_err++;
            d[k] = a ^ b;
            prevc = b;
        end
    endtask

    task automatic rx_frame(input int s,
                            output logic [7:0] pl, output logic [7:0] pr,
                            output logic [27:0] dl, output logic [27:0] dr);
        rx_sub(s, pl, dl);
        rx_sub(s, pr, dr);
    endtask

    task automatic chk_sub(input string tag, input logic [7:0] pre,
                           input logic [7:0] ep, input logic [27:0] d,
                           input logic [23:0] es, input logic ev,
                           input logic ec);
        check({tag, "_pre"}, pre, ep);
        check({tag, "_smp"}, d[23:0], es);
        check({tag, "_cuv"}, d[26:24], {ec, 1'b0, ev});
        check({tag, "_par"}, ^d, 1'b0);
    endtask

    initial begin
        logic [7:0]   pl, pr, p0, p192;
        logic [27:0]  dl, dr;
        logic [191:0] cs;
        logic         c;
        int           n, pe, de, ce, par;

        reset_n = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        bus0.sample_valid = 1'b1;
        bus0.left_data    = 24'h000001;
        bus0.right_data   = 24'h800000;
        bus1.sample_valid = 1'b0;
        bus1.left_data    = 24'h0;
        bus1.right_data   = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_line", line0, 1'b0);
        check("rst_ack", bus0.sample_ack, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_line", line0, 1'b0);
        check("idle_ack", ack0_n, 0);

        // scenario 1
        en0 = 1'b1;
        prevc = 1'b0;
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f0L", pl, PRE_B, dl, 24'h000001, 1'b0, 1'b0);
        chk_sub("f0R", pr, PRE_W, dr, 24'h800000, 1'b0, 1'b0);
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f1L", pl, PRE_M, dl, 24'h000001, 1'b0, 1'b0);
        chk_sub("f1R", pr, PRE_W, dr, 24'h800000, 1'b0, 1'b0);
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f2L", pl, PRE_M, dl, 24'h000001, 1'b0, 1'b1);
        chk_sub("f2R", pr, PRE_W, dr, 24'h800000, 1'b0, 1'b1);
        check("ack_cnt", ack0_n, 3);
        check("ack_gap", ack0_last - ack0_prev, 512);

        // scenario 3
        bus0.left_data  = 24'h123456;
        bus0.right_data = 24'habcdef;
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f3L", pl, PRE_M, dl, 24'h123456, 1'b0, 1'b0);
        chk_sub("f3R", pr, PRE_W, dr, 24'habcdef, 1'b0, 1'b0);
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f4L", pl, PRE_M, dl, 24'h123456, 1'b0, 1'b0);
        chk_sub("f4R", pr, PRE_W, dr, 24'habcdef, 1'b0, 1'b0);
        n = ack0_n;
        bus0.sample_valid = 1'b0;
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("f5L", pl, PRE_M, dl, 24'h0, 1'b1, 1'b0);
        chk_sub("f5R", pr, PRE_W, dr, 24'h0, 1'b1, 1'b0);
        check("f5_noack", ack0_n, n);
        bus0.sample_valid = 1'b1;
        bus0.left_data    = 24'h7fffff;
        bus0.right_data   = 24'h000f0f;
        fork
            rx_frame(0, pl, pr, dl, dr);
            begin
                repeat (300) @(negedge clk);
                bus0.left_data  = 24'h0;
                bus0.right_data = 24'hffffff;
            end
        join
        chk_sub("f6L", pl, PRE_M, dl, 24'h7fffff, 1'b0, 1'b0);
        chk_sub("f6R", pr, PRE_W, dr, 24'h000f0f, 1'b0, 1'b0);
        check("f6_ack", ack0_n, n + 1);

        // scenario 4
        for (int i = 0; i < 71; i++) get_cell(0, c);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        check("dis_line", line0, 1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (line0 !== 1'b0 || bus0.sample_ack !== 1'b0) n++;
        end
        check("dis_hold", n, 0);
        en0 = 1'b1;
        prevc = 1'b0;
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("reL", pl, PRE_B, dl, 24'h0, 1'b0, 1'b0);
        chk_sub("reR", pr, PRE_W, dr, 24'hffffff, 1'b0, 1'b0);

        // scenario 5
        bus0.left_data  = 24'h000001;
        bus0.right_data = 24'h800000;
        n = 0;
        do begin
            get_cell(0, c);
            n++;
        end while (c !== 1'b1 && n < 16);
        check("pre_rst_hi", c, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_line", line0, 1'b0);
        check("arst_ack", bus0.sample_ack, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        prevc = 1'b0;
        n = ack0_n;
        rx_frame(0, pl, pr, dl, dr);
        chk_sub("rsL", pl, PRE_B, dl, 24'h000001, 1'b0, 1'b0);
        chk_sub("rsR", pr, PRE_W, dr, 24'h800000, 1'b0, 1'b0);
        check("rs_ack", ack0_n, n + 1);
        check("line0", line_err, 0);
        en0 = 1'b0;

        // scenarios 2 and 6
        line_err = 0;
        bus1.left_data    = 24'h5a5a5a;
        bus1.right_data   = 24'h0000ff;
        bus1.sample_valid = 1'b1;
        @(negedge clk);
        en1 = 1'b1;
        prevc = 1'b0;
        cs = '0;
        pe = 0;
        de = 0;
        ce = 0;
        par = 0;
        p0 = '0;
        p192 = '0;
        for (int f = 0; f < 193; f++) begin
            rx_frame(1, pl, pr, dl, dr);
            if (f == 0) p0 = pl;
            if (f == 192) p192 = pl;
            if (f != 0 && f != 192 && pl != PRE_M) pe++;
            if (pr != PRE_W) pe++;
            if (dl[25:0] != {2'b00, 24'h5a5a5a}) de++;
            if (dr[25:0] != {2'b00, 24'h0000ff}) de++;
            if (dl[26] != dr[26]) ce++;
            if (f < 192) cs[f] = dl[26];
            if ((^dl) || (^dr)) par++;
        end
        check("blk_B0", p0, PRE_B);
        check("blk_B192", p192, PRE_B);
        check("blk_MW", pe, 0);
        check("blk_data", de, 0);
        check("blk_c_lr", ce, 0);
        check("blk_par", par, 0);
        check("cs_lo", cs[31:0], 32'h0200_0004);
        check("cs_hi", |cs[191:32], 1'b0);
        check("blk_ack", ack1_n, 193);
        check("line1", line_err, 0);
        en1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
